// File: rtl/mem_access_if.sv
// Request/response handshake bundle between the execute stage and the memory-access unit.
// The execute stage is the master; the memory-access unit is the slave.
interface mem_access_if #(
   parameter int REQ_AW = 16,
   parameter int DW     = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [REQ_AW-1:0] req_addr;
   logic [DW-1:0]     req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage sitting in front of a 2**AW x DW data RAM.
// Takes one load/store at a time, range-checks the word address, drives the
// RAM port for exactly one cycle per access and hands back data or a fault.
// Every output is registered; the combinational process computes next values
// and the sequential process captures them.
module mem_access_unit #(
   parameter int AW     = 9,
   parameter int DW     = 16,
   parameter int REQ_AW = 16,
   parameter int ECW    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_access_if.slave    bus,
   output logic [ECW-1:0] err_cnt,
   output logic           m_wr_en,
   output logic [AW-1:0]  m_addr,
   output logic [DW-1:0]  m_wdata,
   input  logic [DW-1:0]  m_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RSP
   } state_t;

   state_t          state, state_d;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q,   rsp_err_d;
   logic [ECW-1:0]  err_cnt_d;
   logic            wr_en_d;
   logic [AW-1:0]   addr_d;
   logic [DW-1:0]   wdata_d;
   logic            addr_fault;

   // Any set bit above the RAM word range is a fault; upper bits never alias into the RAM.
   assign addr_fault = (bus.req_addr >> AW) != '0;

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   // Next-state and next-output logic; everything holds unless a state says otherwise.
   always_comb begin
      state_d     = state;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      err_cnt_d   = err_cnt;
      wr_en_d     = m_wr_en;
      addr_d      = m_addr;
      wdata_d     = m_wdata;

      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr[AW-1:0];
               wdata_d = bus.req_wdata;
               if (addr_fault) begin
                  state_d     = RSP;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  if (err_cnt != {ECW{1'b1}})
                     err_cnt_d = err_cnt + ECW'(1);
               end else if (bus.req_we) begin
                  state_d = WR;
                  wr_en_d = 1'b1;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            rsp_rdata_d = m_rdata;
            rsp_err_d   = 1'b0;
            state_d     = RSP;
         end
         WR: begin
            wr_en_d     = 1'b0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
            state_d     = RSP;
         end
         RSP: begin
            if (bus.rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RSP);
   end

   // State and registered outputs; a low rst_n at the edge wins over everything.
   // A write already underway has committed at the preceding negedge, so clearing
   // m_wr_en here never cancels it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         err_cnt     <= '0;
         m_wr_en     <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
      end else begin
         state       <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         err_cnt     <= err_cnt_d;
         m_wr_en     <= wr_en_d;
         m_addr      <= addr_d;
         m_wdata     <= wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a behavioural RAM
// and a transaction-level reference model of memory contents and fault count.
module tb_mem_access_unit;
   localparam int AW     = 9;
   localparam int DW     = 16;
   localparam int REQ_AW = 16;
   localparam int ECW    = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [ECW-1:0] err_cnt;
   logic           m_wr_en;
   logic [AW-1:0]  m_addr;
   logic [DW-1:0]  m_wdata;
   logic [DW-1:0]  m_rdata;

   mem_access_if #(.REQ_AW(REQ_AW), .DW(DW)) bus();

   mem_access_unit #(.AW(AW), .DW(DW), .REQ_AW(REQ_AW), .ECW(ECW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .err_cnt (err_cnt),
      .m_wr_en (m_wr_en),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Behavioural RAM: loaded with 10*i on the first negedge, writes commit on negedges.
   logic [DW-1:0] ram [0:511];
   logic          ramLoaded = 1'b0;
   always @(negedge clk) begin
      if (!ramLoaded) begin
         for (int i = 0; i < 512; i++) ram[i] <= DW'(10 * i);
         ramLoaded <= 1'b1;
      end else if (m_wr_en) begin
         ram[m_addr] <= m_wdata;
      end
   end
   assign m_rdata = ram[m_addr];

   // Reference model state.
   logic [DW-1:0] refMem [0:511];
   int            refErrCnt;
   int            checks;
   int            errors;

   // Watchdog so the bench always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with the response held off for readyDelay cycles.
   task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                input int readyDelay);
      logic          fault;
      logic [15:0]   expData;
      int            wrCycles;
      int            cyc;
      fault = (addr >= 16'd512);
      if (fault) begin
         expData = '0;
         if (refErrCnt < 255) refErrCnt++;
      end else if (we) begin
         expData = '0;
         refMem[addr[8:0]] = wdata;
      end else begin
         expData = refMem[addr[8:0]];
      end

      checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 16'($urandom);

      wrCycles = 0;
      if (m_wr_en) begin
         wrCycles++;
         checkOutput("wr_addr", 32'(m_addr), 32'(addr[8:0]));
         checkOutput("wr_data", 32'(m_wdata), 32'(wdata));
      end
      checkOutput("rsp_valid_after_accept", 32'(bus.rsp_valid), 32'(fault));
      checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);

      cyc = 0;
      while (!bus.rsp_valid && cyc < 8) begin
         tick();
         cyc++;
         if (m_wr_en) wrCycles++;
      end
      checkOutput("latency", 32'(cyc), fault ? 32'd0 : 32'd1);

      for (int k = 0; k < readyDelay; k++) begin
         tick();
         if (m_wr_en) wrCycles++;
         checkOutput("hold_valid", 32'(bus.rsp_valid), 32'd1);
         checkOutput("hold_rdata", 32'(bus.rsp_rdata), 32'(expData));
         checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end

      checkOutput("rsp_rdata", 32'(bus.rsp_rdata), 32'(expData));
      checkOutput("rsp_err", 32'(bus.rsp_err), 32'(fault));
      checkOutput("wr_en_cycles", 32'(wrCycles), (we && !fault) ? 32'd1 : 32'd0);

      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checkOutput("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
      checkOutput("req_ready_done", 32'(bus.req_ready), 32'd1);
      checkOutput("err_cnt", 32'(err_cnt), 32'(refErrCnt));
   endtask

   initial begin
      logic [15:0] a;
      checks = 0;
      errors = 0;
      refErrCnt = 0;
      for (int i = 0; i < 512; i++) refMem[i] = DW'(10 * i);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;

      // Reset values.
      rst_n = 1'b0;
      repeat (3) tick();
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("rst_wr_en", 32'(m_wr_en), 32'd0);
      checkOutput("rst_m_addr", 32'(m_addr), 32'd0);
      checkOutput("rst_m_wdata", 32'(m_wdata), 32'd0);
      rst_n = 1'b1;
      tick();

      // Directed cases.
      applyStimulus(1'b0, 16'd3, 16'h0, 0);
      checkOutput("load3_const", 32'(bus.rsp_rdata), 32'h001E);
      applyStimulus(1'b1, 16'd5, 16'h1234, 0);
      applyStimulus(1'b0, 16'd5, 16'h0, 0);
      checkOutput("load5_const", 32'(bus.rsp_rdata), 32'h1234);
      applyStimulus(1'b1, 16'h0200, 16'hDEAD, 0);
      checkOutput("fault_cnt_const", 32'(err_cnt), 32'd1);
      applyStimulus(1'b0, 16'd0, 16'h0, 0);
      applyStimulus(1'b0, 16'd100, 16'h0, 4);

      // Reset while in RD: the pending response disappears.
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 16'd7;
      tick();
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      refErrCnt = 0;
      checkOutput("rd_rst_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("rd_rst_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("rd_rst_wr_en", 32'(m_wr_en), 32'd0);
      checkOutput("rd_rst_err_cnt", 32'(err_cnt), 32'd0);
      repeat (3) begin
         tick();
         checkOutput("rd_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end

      // Reset while in WR: the write has already landed in the RAM.
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 16'd9;
      bus.req_wdata = 16'hBEEF;
      tick();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      checkOutput("wr_rst_wr_en_high", 32'(m_wr_en), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      refMem[9] = 16'hBEEF;
      checkOutput("wr_rst_wr_en_low", 32'(m_wr_en), 32'd0);
      checkOutput("wr_rst_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
      applyStimulus(1'b0, 16'd9, 16'h0, 0);

      // Saturate the fault counter.
      for (int i = 0; i < 300; i++)
         applyStimulus(1'($urandom), 16'($urandom_range(512, 65535)), 16'($urandom), 0);
      checkOutput("err_cnt_sat", 32'(err_cnt), 32'hFF);

      // Random mix of loads, stores and faults.
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 7))
            0:       a = 16'($urandom_range(512, 65535));
            1, 2, 3: a = 16'($urandom_range(0, 15));
            default: a = 16'($urandom_range(0, 511));
         endcase
         applyStimulus(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)));
      end
      checkOutput("err_cnt_sat_end", 32'(err_cnt), 32'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
